// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, frame shape and TX state encoding.
package uart_pkg;

    // 27 MHz system clock / 115200 baud
    localparam int unsigned DELAY_FRAMES_DEFAULT = 234;

    localparam int unsigned CNT_W      = 13;
    localparam int unsigned BIT_IDX_W  = 3;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Serial line level driven while the transmitter sits in a given state
    function automatic logic line_level(input tx_state_e st, input logic data_bit);
        logic lvl;
        lvl = 1'b1;
        case (st)
            TX_START: lvl = 1'b0;
            TX_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DELAY_FRAMES-1 and flags the last cycle of each period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DELAY_FRAMES_DEFAULT
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_FRAMES - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Next count: hold at zero on restart, wrap after the last cycle of a period
    always_comb begin
        count_next = count;
        if (restart || (count == LAST)) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(1);
        end
    end

    // bit_done is registered from the next count, so it is high exactly while count == LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            bit_done <= 1'b0;
        end else begin
            count    <= count_next;
            bit_done <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a one-entry holding register for back-to-back frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DELAY_FRAMES_DEFAULT
)
(
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 tx_busy
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_e            state;
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] hold_data;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic                 hold_empty;
    logic                 accept;
    logic                 bit_done;
    logic                 baud_restart;

    // Ready is the holding-register-empty flop itself; no path from tx_valid
    assign tx_ready     = hold_empty;
    assign accept       = tx_valid && hold_empty;
    // Counter sits at zero while idle so a loaded frame starts a fresh bit period
    assign baud_restart = (state == TX_IDLE);

    uart_baud_tick #(
        .DELAY_FRAMES (DELAY_FRAMES)
    ) u_baud (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .restart  (baud_restart),
        .bit_done (bit_done)
    );

    // Frame sequencer, holding register and registered line/busy outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= TX_IDLE;
            shifter    <= '0;
            hold_data  <= '0;
            bit_idx    <= '0;
            hold_empty <= 1'b1;
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            uart_tx <= line_level(state, shifter[0]);
            tx_busy <= (state != TX_IDLE) || !hold_empty;

            // Accept and load never coincide: accept needs empty, load needs full
            if (accept) begin
                hold_data  <= tx_data;
                hold_empty <= 1'b0;
            end

            case (state)
                TX_IDLE: begin
                    if (!hold_empty) begin
                        shifter    <= hold_data;
                        hold_empty <= 1'b1;
                        state      <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        bit_idx <= '0;
                        state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        shifter <= shifter >> 1;
                        bit_idx <= bit_idx + BIT_IDX_W'(1);
                        if (bit_idx == LAST_BIT) begin
                            state <= TX_STOP;
                        end
                    end
                end
                TX_STOP: begin
                    if (bit_done) begin
                        if (!hold_empty) begin
                            shifter    <= hold_data;
                            hold_empty <= 1'b1;
                            state      <= TX_START;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level reference model plus directed literal checks.
module tb_uart_tx_buffered;

    localparam int unsigned D0     = 234;
    localparam int unsigned D1     = 4;
    localparam int unsigned BUDGET = 30000;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] tx_data  [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic       uart_tx  [2];
    logic       tx_busy  [2];

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    bit          chk_on = 1'b0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    uart_tx_buffered #(.DELAY_FRAMES(D0)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_data   (tx_data[0]),
        .tx_valid  (tx_valid[0]),
        .tx_ready  (tx_ready[0]),
        .uart_tx   (uart_tx[0]),
        .tx_busy   (tx_busy[0])
    );

    uart_tx_buffered #(.DELAY_FRAMES(D1)) dut_short (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_data   (tx_data[1]),
        .tx_valid  (tx_valid[1]),
        .tx_ready  (tx_ready[1]),
        .uart_tx   (uart_tx[1]),
        .tx_busy   (tx_busy[1])
    );

    function automatic int unsigned dly(input bit i);
        return i ? D1 : D0;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model: frames as 10-bit line patterns ----------------
    bit          m_active [2];
    bit          m_full   [2];
    logic [7:0]  m_hold   [2];
    logic [9:0]  m_frame  [2];
    int unsigned m_pos    [2];
    logic        e_tx     [2];
    logic        e_ready  [2];
    logic        e_busy   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0;
            m_full[k]   = 1'b0;
            m_hold[k]   = 8'h00;
            m_frame[k]  = 10'h3FF;
            m_pos[k]    = 0;
            e_tx[k]     = 1'b1;
            e_ready[k]  = 1'b1;
            e_busy[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input bit i);
        int unsigned d;
        bit          acc;
        bit          fend;
        logic [9:0]  tmp;
        d    = dly(i);
        acc  = tx_valid[i] && !m_full[i];
        fend = m_active[i] && (m_pos[i] == 10 * d - 1);
        tmp  = m_frame[i] >> (m_pos[i] / d);
        // outputs after this edge reflect the line/busy condition before it
        e_tx[i]   = m_active[i] ? tmp[0] : 1'b1;
        e_busy[i] = m_active[i] || m_full[i];
        if (m_active[i]) m_pos[i]++;
        if ((!m_active[i] || fend) && m_full[i]) begin
            m_frame[i]  = {1'b1, m_hold[i], 1'b0};
            m_pos[i]    = 0;
            m_active[i] = 1'b1;
            m_full[i]   = 1'b0;
        end else if (fend) begin
            m_active[i] = 1'b0;
        end
        if (acc) begin
            m_full[i] = 1'b1;
            m_hold[i] = tx_data[i];
        end
        e_ready[i] = !m_full[i];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                model_reset();
            end else begin
                model_step(1'b0);
                model_step(1'b1);
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_on) begin
                check_bit("cyc_uart_tx_d234", uart_tx[0], e_tx[0]);
                check_bit("cyc_tx_ready_d234", tx_ready[0], e_ready[0]);
                check_bit("cyc_tx_busy_d234", tx_busy[0], e_busy[0]);
                check_bit("cyc_uart_tx_d4", uart_tx[1], e_tx[1]);
                check_bit("cyc_tx_ready_d4", tx_ready[1], e_ready[1]);
                check_bit("cyc_tx_busy_d4", tx_busy[1], e_busy[1]);
            end
        end
    end

    // ---------------- stimulus helpers (all entered at a negedge) ----------------
    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic send(input bit i, input logic [7:0] b, output int unsigned acc);
        bit done;
        done        = 1'b0;
        acc         = 0;
        tx_data[i]  = b;
        tx_valid[i] = 1'b1;
        for (int n = 0; n < BUDGET && !done; n++) begin
            if (tx_ready[i]) begin
                @(posedge sys_clk);
                @(negedge sys_clk);
                acc  = cyc;
                done = 1'b1;
            end else begin
                @(negedge sys_clk);
            end
        end
        if (!done) timeout("send_accept");
    endtask

    task automatic wait_idle(input bit i, output int unsigned at);
        bit done;
        done = 1'b0;
        at   = 0;
        for (int n = 0; n < BUDGET && !done; n++) begin
            @(negedge sys_clk);
            if (tx_busy[i] == 1'b0) begin
                at   = cyc;
                done = 1'b1;
            end
        end
        if (!done) timeout("wait_idle");
    endtask

    // Independent line decoder: mid-bit sampling, LSB first
    task automatic decode(input bit i, output logic [7:0] b, output int unsigned fall, output logic stop_ok);
        int unsigned d;
        bit seen;
        d       = dly(i);
        seen    = 1'b0;
        b       = 8'h00;
        fall    = 0;
        stop_ok = 1'b0;
        for (int n = 0; n < BUDGET && !seen; n++) begin
            @(negedge sys_clk);
            if (uart_tx[i] == 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            timeout("decode_start_bit");
            return;
        end
        fall = cyc;
        for (int k = 0; k < 8; k++) begin
            wait_until(fall + (k + 1) * d + d / 2);
            b = {uart_tx[i], b[7:1]};
        end
        wait_until(fall + 9 * d + d / 2);
        stop_ok = uart_tx[i];
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int unsigned acc, acc1, acc3, fall, at, lows;
        int unsigned f1, f2, f3, a2;
        logic [7:0]  b1, b2, b3, b;
        logic        s1, s2, s3, s;
        logic [9:0]  frm, tmp;

        sys_rst_n   = 1'b1;
        tx_valid[0] = 1'b0;
        tx_valid[1] = 1'b0;
        tx_data[0]  = 8'h00;
        tx_data[1]  = 8'h00;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_on = 1'b1;
        check_bit("reset_uart_tx", uart_tx[0], 1'b1);
        check_bit("reset_tx_ready", tx_ready[0], 1'b1);
        check_bit("reset_tx_busy", tx_busy[0], 1'b0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single byte 0xA3
        frm = 10'b11_0100_0110;
        send(1'b0, 8'hA3, acc);
        tx_valid[0] = 1'b0;
        fall = acc + 2;
        wait_until(fall - 1);
        check_bit("a3_line_high_before_start", uart_tx[0], 1'b1);
        for (int k = 0; k < 10; k++) begin
            wait_until(fall + k * D0 + D0 / 2);
            tmp = frm >> k;
            check_bit("a3_frame_bit", uart_tx[0], tmp[0]);
        end
        wait_idle(1'b0, at);
        check_int("a3_busy_drop_after_start", at - fall, 10 * D0);

        // Back-to-back frames with valid held high
        fork
            begin
                send(1'b0, 8'h55, acc);
                send(1'b0, 8'h0F, acc);
                check_bit("b2b_ready_low_after_accept", tx_ready[0], 1'b0);
                send(1'b0, 8'hF0, acc);
                tx_valid[0] = 1'b0;
            end
            begin
                decode(1'b0, b1, f1, s1);
                decode(1'b0, b2, f2, s2);
                decode(1'b0, b3, f3, s3);
            end
        join
        check_int("b2b_byte0", 32'(b1), 32'h55);
        check_int("b2b_byte1", 32'(b2), 32'h0F);
        check_int("b2b_byte2", 32'(b3), 32'hF0);
        check_bit("b2b_stop0", s1, 1'b1);
        check_bit("b2b_stop2", s3, 1'b1);
        check_int("b2b_gap01", f2 - f1, 10 * D0);
        check_int("b2b_gap12", f3 - f2, 10 * D0);
        wait_idle(1'b0, at);

        // Handshake: third byte must wait for the STOP->START reload
        send(1'b0, 8'h11, acc1);
        send(1'b0, 8'h22, a2);
        check_int("hs_second_accept", a2, acc1 + 2);
        tx_data[0]  = 8'h33;
        tx_valid[0] = 1'b1;
        repeat (50) @(negedge sys_clk);
        check_bit("hs_ready_low_when_full", tx_ready[0], 1'b0);
        send(1'b0, 8'h33, acc3);
        tx_valid[0] = 1'b0;
        check_int("hs_third_accept", acc3, acc1 + 2 + 10 * D0);
        wait_idle(1'b0, at);

        // Reset during data bit 4 of 0x3C with a byte held
        send(1'b0, 8'h3C, acc);
        send(1'b0, 8'h99, a2);
        tx_valid[0] = 1'b0;
        fall = acc + 2;
        wait_until(fall + 5 * D0 + D0 / 2);
        check_bit("rst_pre_busy", tx_busy[0], 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_bit("rst_async_uart_tx", uart_tx[0], 1'b1);
        check_bit("rst_async_tx_ready", tx_ready[0], 1'b1);
        check_bit("rst_async_tx_busy", tx_busy[0], 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        lows = 0;
        for (int n = 0; n < 12 * D0; n++) begin
            @(negedge sys_clk);
            if (uart_tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) lows++;
        end
        check_int("rst_no_frame_after_release", lows, 0);

        // Short baud: DELAY_FRAMES=4, byte 0x81, 40-clock frame
        frm = 10'b11_0000_0010;
        send(1'b1, 8'h81, acc);
        tx_valid[1] = 1'b0;
        fall = acc + 2;
        wait_until(fall - 1);
        check_bit("d4_line_high_before_start", uart_tx[1], 1'b1);
        for (int k = 0; k < 10; k++) begin
            tmp = frm >> k;
            wait_until(fall + k * D1);
            check_bit("d4_bit_first_clk", uart_tx[1], tmp[0]);
            wait_until(fall + k * D1 + D1 - 1);
            check_bit("d4_bit_last_clk", uart_tx[1], tmp[0]);
        end
        check_bit("d4_busy_last_clk", tx_busy[1], 1'b1);
        wait_until(fall + 10 * D1);
        check_bit("d4_busy_after_40", tx_busy[1], 1'b0);
        check_bit("d4_line_after_40", uart_tx[1], 1'b1);

        // Loopback-style decode of 0x0A
        fork
            begin
                send(1'b0, 8'h0A, acc);
                tx_valid[0] = 1'b0;
            end
            decode(1'b0, b, f1, s);
        join
        check_int("loop_nibble", 32'(b[3:0]), 32'hA);
        check_int("loop_byte", 32'(b), 32'h0A);
        check_bit("loop_stop", s, 1'b1);
        wait_idle(1'b0, at);

        chk_on = 1'b0;
        @(negedge sys_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
